// File: rtl/rf_multiport.sv
// rf_multiport: parametrised register file with NUM_RD registered read ports,
// two write ports and a per-register pending scoreboard for load hazards.
//
// Parameters: DATA_W (register width), ADDR_W (depth = 2**ADDR_W),
//             NUM_RD (read ports, 1..4), ZERO_REG (1 = reg 0 reads zero, never pending)
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   rd_addr / rd_data / rd_pend packed read ports (port k at k*W +: W), 1-cycle latency
//   wa_en/wa_addr/wa_data      write port A (ALU writeback, wins on collision)
//   wb_en/wb_addr/wb_data      write port B (load return)
//   rsv_en/rsv_addr            mark destination register pending
//   pend_cnt                   registered count of pending registers
// Build option: define RF_BYPASS_EN to forward same-edge writes and the
// post-update pend bit into the read registers.
module rf_multiport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pend,
  input  logic                     wa_en,
  input  logic [ADDR_W-1:0]        wa_addr,
  input  logic [DATA_W-1:0]        wa_data,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic [ADDR_W:0]          pend_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic [DEPTH-1:0]  pendNext;
  logic [ADDR_W:0]   cntNext;
  logic              waOk, wbOk, wbStore, rsvOk;
  logic [NUM_RD*DATA_W-1:0] rdDataNext;
  logic [NUM_RD-1:0]        rdPendNext;

  // Writes/reserves to the hardwired zero register are dropped entirely.
  always_comb begin
    waOk    = wa_en  && !((ZERO_REG != 0) && (wa_addr  == '0));
    wbOk    = wb_en  && !((ZERO_REG != 0) && (wb_addr  == '0));
    rsvOk   = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));
    // A colliding B write still clears pend (same address as A) but stores nothing.
    wbStore = wbOk && !(waOk && (wb_addr == wa_addr));
  end

  // Clears first, reserve last, so a same-edge reserve wins over a write.
  always_comb begin
    pendNext = pend;
    if (waOk)  pendNext[wa_addr]  = 1'b0;
    if (wbOk)  pendNext[wb_addr]  = 1'b0;
    if (rsvOk) pendNext[rsv_addr] = 1'b1;
    cntNext = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      cntNext = cntNext + {{ADDR_W{1'b0}}, pendNext[i]};
  end

  always_comb begin
    rdDataNext = '0;
    rdPendNext = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      logic [ADDR_W-1:0] a;
      a = rd_addr[k*ADDR_W +: ADDR_W];
`ifdef RF_BYPASS_EN
      if (waOk && (wa_addr == a))
        rdDataNext[k*DATA_W +: DATA_W] = wa_data;
      else if (wbStore && (wb_addr == a))
        rdDataNext[k*DATA_W +: DATA_W] = wb_data;
      else
        rdDataNext[k*DATA_W +: DATA_W] = regs[a];
      rdPendNext[k] = pendNext[a];
`else
      rdDataNext[k*DATA_W +: DATA_W] = regs[a];
      rdPendNext[k] = pend[a];
`endif
      if ((ZERO_REG != 0) && (a == '0)) begin
        rdDataNext[k*DATA_W +: DATA_W] = '0;
        rdPendNext[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        regs[i] <= '0;
      pend     <= '0;
      rd_data  <= '0;
      rd_pend  <= '0;
      pend_cnt <= '0;
    end else begin
      if (waOk)    regs[wa_addr] <= wa_data;
      if (wbStore) regs[wb_addr] <= wb_data;
      pend     <= pendNext;
      rd_data  <= rdDataNext;
      rd_pend  <= rdPendNext;
      pend_cnt <= cntNext;
    end
  end

endmodule
